// File: rtl/field_packer_32.sv
// Packs variable-width fields (0..32 bits) LSB-first into 32-bit words on a
// valid/ready output. A flush command drains the partial final word with its bit count.

module cut_32 #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 6
) (
  input  logic [LEN_W-1:0]  n,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);
  // For n == 32 the shifted mask would need 33 bits, so pass the input through unchanged.
  assign dout = (n >= LEN_W'(DATA_W)) ? din : (din & ~({DATA_W{1'b1}} << n));
endmodule

module field_packer_32 #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [LEN_W-1:0]  in_len,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [LEN_W-1:0]  out_bits,
  output logic              flush_done,
  output logic              busy
);

  typedef enum logic {RUN, FLUSH} state_e;

  localparam logic [LEN_W-1:0] FULL = LEN_W'(DATA_W);

  state_e              state_q, state_d;
  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [LEN_W-1:0]    fill_q, fill_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [LEN_W-1:0]    out_bits_q, out_bits_d;
  logic                flush_done_q, flush_done_d;

  logic [LEN_W-1:0]    len_c;
  logic [DATA_W-1:0]   field;
  logic                slot_free;
  logic                emit;
  logic                accept;
  logic [2*DATA_W-1:0] acc_base;
  logic [LEN_W-1:0]    fill_base;

  assign len_c = (in_len > FULL) ? FULL : in_len;

  cut_32 #(.DATA_W(DATA_W), .LEN_W(LEN_W)) u_cut (
    .n    (len_c),
    .din  (in_data),
    .dout (field)
  );

  assign slot_free = !out_valid_q || out_ready;
  assign emit      = (fill_q >= FULL) && slot_free;
  assign in_ready  = (state_q == RUN) && ((fill_q < FULL) || emit);
  assign accept    = in_valid && in_ready;
  assign acc_base  = emit ? {{DATA_W{1'b0}}, acc_q[2*DATA_W-1:DATA_W]} : acc_q;
  assign fill_base = emit ? (fill_q - FULL) : fill_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d      = state_q;
    acc_d        = acc_base;
    fill_d       = fill_base;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_bits_d   = out_bits_q;
    flush_done_d = 1'b0;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (emit) begin
      out_data_d  = acc_q[DATA_W-1:0];
      out_bits_d  = FULL;
      out_valid_d = 1'b1;
    end

    // Base never exceeds 31 and len never exceeds 32, so fill stays within 63.
    if (accept && (len_c != '0)) begin
      acc_d  = acc_base | ({{DATA_W{1'b0}}, field} << fill_base);
      fill_d = fill_base + len_c;
    end

    case (state_q)
      RUN: begin
        if (flush) state_d = FLUSH;
      end
      FLUSH: begin
        if ((fill_q < FULL) && slot_free) begin
          if (fill_q != '0) begin
            out_data_d  = acc_q[DATA_W-1:0];
            out_bits_d  = fill_q;
            out_valid_d = 1'b1;
            acc_d       = '0;
            fill_d      = '0;
          end
          flush_done_d = 1'b1;
          state_d      = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      acc_q        <= '0;
      fill_q       <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_bits_q   <= '0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      fill_q       <= fill_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_bits_q   <= out_bits_d;
      flush_done_q <= flush_done_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_bits   = out_bits_q;
  assign flush_done = flush_done_q;
  assign busy       = (fill_q != '0) || out_valid_q || (state_q != RUN);

endmodule

// File: tb/tb_field_packer_32.sv
// Bench for field_packer_32: table-driven single-field cases, directed multi-cycle
// sequences, and a randomized run against a bit-queue reference model.

module tb_field_packer_32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [5:0]  in_len;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [5:0]  out_bits;
  logic        flush_done;
  logic        busy;

  field_packer_32 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_len     (in_len),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_bits   (out_bits),
    .flush_done (flush_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [5:0]  bits;
  } word_t;

  typedef struct {
    logic [31:0] data;
    logic [5:0]  len;
    logic [31:0] exp_data;
    logic [5:0]  exp_bits;  // 0 means no word is expected
  } row_t;

  int    errors = 0;
  int    checks = 0;
  word_t got_q[$];
  word_t exp_q[$];
  bit    bitq[$];
  int    done_cnt;
  bit    done_with_valid;
  bit    prev_done;
  bit    hold_pending;
  word_t hold_word;
  bit    use_model;
  bit    pend;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Reference model: fields become individual bits; words are cut from the bit stream.
  task automatic model_push(input logic [31:0] data, input logic [5:0] len);
    int n;
    n = (len > 6'd32) ? 32 : int'(len);
    for (int i = 0; i < n; i++) bitq.push_back(data[i]);
    while (bitq.size() >= 32) begin
      word_t w;
      w.data = '0;
      for (int i = 0; i < 32; i++) w.data[i] = bitq.pop_front();
      w.bits = 6'd32;
      exp_q.push_back(w);
    end
  endtask

  task automatic model_flush();
    if (bitq.size() > 0) begin
      word_t w;
      w.data = '0;
      w.bits = 6'(bitq.size());
      for (int i = 0; bitq.size() > 0; i++) w.data[i] = bitq.pop_front();
      exp_q.push_back(w);
    end
  endtask

  // One clock: inputs are set by the caller at posedge+1, sampled at posedge+2.
  task automatic cyc();
    bit took_in;
    bit took_out;
    #1;
    if (flush_done) begin
      done_cnt++;
      done_with_valid = out_valid;
      if (prev_done) check("flush_done_one_cycle", 1, 0);
      if (use_model) begin
        check("flush_done_expected", pend, 1);
        pend = 0;
      end
    end
    prev_done = flush_done;
    if (hold_pending) begin
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, hold_word.data);
      check("hold_bits", out_bits, hold_word.bits);
    end
    if (use_model && pend) check("in_ready_during_flush", in_ready, 0);
    took_in  = in_valid && in_ready;
    took_out = out_valid && out_ready;
    if (took_out) begin
      if (use_model) begin
        if (exp_q.size() == 0) begin
          check("rand_unexpected_word", {out_bits, out_data}, 0);
        end else begin
          word_t e;
          e = exp_q.pop_front();
          check("rand_word_data", out_data, e.data);
          check("rand_word_bits", out_bits, e.bits);
        end
      end else begin
        word_t w;
        w.data = out_data;
        w.bits = out_bits;
        got_q.push_back(w);
      end
    end
    if (use_model) begin
      if (took_in) model_push(in_data, in_len);
      if (flush && !pend) begin
        pend = 1;
        model_flush();
      end
    end
    hold_pending   = out_valid && !out_ready;
    hold_word.data = out_data;
    hold_word.bits = out_bits;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0;
    in_data  = '0;
    in_len   = '0;
    flush    = 0;
  endtask

  task automatic run_row(input row_t r, input int idx);
    got_q.delete();
    done_cnt = 0;
    done_with_valid = 0;
    out_ready = 1;
    in_valid  = 1;
    in_data   = r.data;
    in_len    = r.len;
    cyc();
    idle_inputs();
    flush = 1;
    cyc();
    flush = 0;
    repeat (5) cyc();
    check($sformatf("row%0d_done_count", idx), done_cnt, 1);
    if (r.exp_bits == 0) begin
      check($sformatf("row%0d_word_count", idx), got_q.size(), 0);
    end else begin
      check($sformatf("row%0d_word_count", idx), got_q.size(), 1);
      if (got_q.size() > 0) begin
        check($sformatf("row%0d_data", idx), got_q[0].data, r.exp_data);
        check($sformatf("row%0d_bits", idx), got_q[0].bits, r.exp_bits);
      end
      if (r.exp_bits != 6'd32) check($sformatf("row%0d_done_with_valid", idx), done_with_valid, 1);
    end
    check($sformatf("row%0d_busy", idx), busy, 0);
  endtask

  initial begin
    row_t        rows[7];
    logic [31:0] bytes[4];

    rows[0] = '{32'hFFFF_FFFF, 6'd12, 32'h0000_0FFF, 6'd12};
    rows[1] = '{32'hDEAD_BEEF, 6'd0,  32'h0,         6'd0};
    rows[2] = '{32'h89AB_CDEF, 6'd40, 32'h89AB_CDEF, 6'd32};
    rows[3] = '{32'h1234_5678, 6'd32, 32'h1234_5678, 6'd32};
    rows[4] = '{32'hFFFF_FFFF, 6'd1,  32'h0000_0001, 6'd1};
    rows[5] = '{32'hFFFF_FFFF, 6'd31, 32'h7FFF_FFFF, 6'd31};
    rows[6] = '{32'h0000_00A5, 6'd4,  32'h0000_0005, 6'd4};
    bytes   = '{32'hA1, 32'hB2, 32'hC3, 32'hD4};

    use_model = 0;
    pend = 0;
    prev_done = 0;
    hold_pending = 0;
    idle_inputs();
    out_ready = 1;
    rst_n = 0;
    #12;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    check("reset_out_bits", out_bits, 0);
    check("reset_flush_done", flush_done, 0);
    check("reset_busy", busy, 0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;

    // Four bytes form one full word; it appears one edge after the completing accept.
    got_q.delete();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1;
      in_data  = bytes[i];
      in_len   = 6'd8;
      cyc();
    end
    idle_inputs();
    check("t1_not_yet_valid", out_valid, 0);
    cyc();
    check("t1_valid_next_edge", out_valid, 1);
    repeat (3) cyc();
    check("t1_word_count", got_q.size(), 1);
    if (got_q.size() > 0) begin
      check("t1_data", got_q[0].data, 32'hD4C3_B2A1);
      check("t1_bits", got_q[0].bits, 6'd32);
    end
    check("t1_busy", busy, 0);

    foreach (rows[i]) run_row(rows[i], i);

    // Straddling field splits across a full word and a flushed partial word.
    got_q.delete();
    in_valid = 1; in_data = 32'h00AB_CDEF; in_len = 6'd24; cyc();
    in_data = 32'h0000_1234; in_len = 6'd16; cyc();
    idle_inputs();
    flush = 1; cyc(); flush = 0;
    repeat (6) cyc();
    check("t3_word_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("t3_w0_data", got_q[0].data, 32'h34AB_CDEF);
      check("t3_w0_bits", got_q[0].bits, 6'd32);
      check("t3_w1_data", got_q[1].data, 32'h0000_0012);
      check("t3_w1_bits", got_q[1].bits, 6'd8);
    end

    // Backpressure: the second field enters as the first word moves to the output.
    got_q.delete();
    out_ready = 0;
    in_valid = 1; in_data = 32'h1111_1111; in_len = 6'd32; cyc();
    in_data = 32'h2222_2222; cyc();
    check("t4_second_accepted_fill", dut.fill_q, 6'd32);
    idle_inputs();
    repeat (3) cyc();
    check("t4_held_valid", out_valid, 1);
    check("t4_held_data", out_data, 32'h1111_1111);
    check("t4_in_ready_low", in_ready, 0);
    out_ready = 1;
    repeat (4) cyc();
    check("t4_word_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("t4_w0", got_q[0].data, 32'h1111_1111);
      check("t4_w1", got_q[1].data, 32'h2222_2222);
    end

    // Asynchronous reset with buffered bits and a held output word.
    out_ready = 0;
    in_valid = 1; in_data = 32'hFFFF_FFFF; in_len = 6'd32; cyc();
    in_data = 32'h000A_BCDE; in_len = 6'd20; cyc();
    idle_inputs();
    check("t6_pre_valid", out_valid, 1);
    check("t6_pre_busy", busy, 1);
    #2;
    rst_n = 0;
    #1;
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_data", out_data, 0);
    check("t6_rst_bits", out_bits, 0);
    check("t6_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1;
    hold_pending = 0;
    prev_done = 0;
    @(posedge clk);
    #1;
    out_ready = 1;
    got_q.delete();
    done_cnt = 0;
    flush = 1; cyc(); flush = 0;
    repeat (4) cyc();
    check("t6_flush_done_count", done_cnt, 1);
    check("t6_no_word", got_q.size(), 0);

    // Randomized traffic against the bit-queue model.
    use_model = 1;
    pend = 0;
    bitq.delete();
    exp_q.delete();
    for (int k = 0; k < 3000; k++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = $urandom;
      in_len    = ($urandom_range(0, 3) == 0) ? 6'd32 : 6'($urandom_range(0, 63));
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = !pend && ($urandom_range(0, 39) == 0);
      cyc();
    end
    idle_inputs();
    out_ready = 1;
    if (!pend) begin
      flush = 1;
      cyc();
      flush = 0;
    end
    for (int k = 0; k < 200; k++) begin
      if (!pend && exp_q.size() == 0 && !out_valid) break;
      cyc();
    end
    check("drain_exp_empty", exp_q.size(), 0);
    check("drain_flush_done_seen", pend, 0);
    check("drain_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/field_packer_32.md
Name: field_packer_32

Overview:
- Downstream companion of the CUT_32 truncation stage in the ALU datapath.
- Accepts a stream of variable-width fields (0..32 bits), masks each to its width through an internal CUT_32 instance, and packs the fields LSB-first into contiguous 32-bit words.
- Words are emitted on a valid/ready output. A flush command drains a partial final word together with its bit count.

Parameters:
- DATA_W, 32, word and maximum field width; fixed at 32.
- LEN_W, 6, width of in_len and out_bits.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  field present.
- in_ready  output  1  field accepted when in_valid && in_ready.
- in_data  input  32  field data; only the low in_len bits are used.
- in_len  input  6  field width. 0 = no-op. Values above 32 are clamped to 32.
- flush  input  1  single-cycle request to emit the partial word.
- out_valid  output  1  out_data/out_bits valid.
- out_ready  input  1  consumer accepts when out_valid && out_ready.
- out_data  output  32  packed word; unused upper bits are 0.
- out_bits  output  6  valid bits in out_data: 32 for a full word, 1..31 for a flush word.
- flush_done  output  1  one-cycle pulse when a flush completes.
- busy  output  1  fill != 0 || out_valid || state != RUN.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - acc (64-bit) = 0, fill (6-bit) = 0, state = RUN.
  - out_valid = 0, out_data = 0, out_bits = 0, flush_done = 0.
  - Reset mid-operation discards all buffered bits and any pending flush.
- Masking: field = CUT_32(n = min(in_len, 32), in = in_data), so bits at or above len are zeroed.
- Emit condition: emit = fill >= 32 && (!out_valid || out_ready).
  - On emit: out_data <= acc[31:0], out_bits <= 32, out_valid <= 1, acc <= acc >> 32, fill <= fill - 32.
- Output holding:
  - out_valid && out_ready with no new emit clears out_valid.
  - out_data and out_bits stay stable while out_valid && !out_ready.
- Input ready: in_ready = (state == RUN) && (fill < 32 || emit). This is combinational on out_ready.
- Accept: uses base = fill - 32 if emit in the same cycle, else base = fill.
  - acc <= (shifted acc) | (field << base); fill <= base + len.
  - Maximum fill is 63, so there is no overflow.
  - Latency: a word completed by an accept is presented on out_valid at the second rising edge after that accept.
  - Full throughput: one 32-bit field per cycle yields one word per cycle.
- len = 0: accepted handshake, no state change.
- FSM states:
  - RUN: normal operation. If flush is sampled high, go to FLUSH. A field accepted in the same cycle is included in the flush.
  - FLUSH: in_ready = 0; full words are emitted as normal.
    - When fill < 32 and the output slot is free (!out_valid || out_ready):
      - fill > 0: out_data <= acc[31:0], out_bits <= fill, out_valid <= 1, acc <= 0, fill <= 0, flush_done <= 1, go to RUN.
      - fill == 0: flush_done <= 1, go to RUN with no word emitted.
  - flush asserted while in FLUSH is ignored.
- flush_done is high for exactly one cycle, then returns to 0.

Test Plan:
1. Fields 0xA1, 0xB2, 0xC3, 0xD4 (len 8 each), out_ready=1 -> exactly one word 0xD4C3B2A1 with out_bits=32; busy returns to 0.
2. in_data=0xFFFFFFFF, len=12, then flush -> out_data=0x00000FFF, out_bits=12, flush_done pulses once on the same edge that sets out_valid.
3. Straddle: 0xABCDEF (len 24), then 0x1234 (len 16), then flush -> word 0x34ABCDEF (bits 32), then 0x00000012 (bits 8).
4. Backpressure: out_ready=0, push 0x11111111 and 0x22222222 (len 32) -> first word held stable and in_ready=0 with fill=32. Then raise out_ready -> 0x11111111, then 0x22222222; no loss or duplication.
5. Clamping and zero length: len=0 with data 0xDEADBEEF (no effect), then len=40 with 0x89ABCDEF -> word 0x89ABCDEF, bits 32.
6. Reset mid-op: with fill=20 and out_valid=1, pulse rst_n low asynchronously -> all outputs 0 immediately. Then flush with fill=0 -> flush_done pulse and no out_valid.
